// File: rtl/cmplx_mult_pkg.sv
// Shared types and switch-bus bit positions for the complex multiplier driver.
// WORD_SIZE mirrors `WORD_SIZE; SW_* name the top bits of the SW bus.
package cmplx_mult_pkg;

  localparam int unsigned WORD_SIZE  = 8;
  localparam int unsigned SW_HS_BIT  = WORD_SIZE;
  localparam int unsigned SW_RST_BIT = WORD_SIZE + 1;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [3:0] {
    INIT_RST = 4'd0,
    INIT_REL = 4'd1,
    IDLE     = 4'd2,
    WORD_HI  = 4'd3,
    WORD_LO  = 4'd4,
    RES_RE   = 4'd5,
    RES_IM   = 4'd6,
    RES_END  = 4'd7,
    OUT      = 4'd8
  } drv_state_t;

endpackage

// File: rtl/phase_timer.sv
// Down-counter that times one handshake phase; reloads on load and flags the
// final cycle of the phase with done.
module phase_timer #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic [CNT_W-1:0] cnt_r;

  // phase counter: loaded in reset so the first phase is already armed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_LOAD;
    end else if (load) begin
      cnt_r <= CNT_LOAD;
    end else if (cnt_r != CNT_ONE) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == CNT_ONE);

endmodule

// File: rtl/cmplx_mult_driver.sv
// Plays the operator of the complex multiplier: resets it, walks one operand
// frame onto the switch bus with timed handshakes, and reads both results back.
module cmplx_mult_driver
  import cmplx_mult_pkg::*;
#(
  parameter int WORD_W      = WORD_SIZE,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_re_a,
  input  logic [WORD_W-1:0] in_im_a,
  input  logic [WORD_W-1:0] in_re_q,
  input  logic [WORD_W-1:0] in_im_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_re,
  output logic [WORD_W-1:0] out_im,
  output logic [WORD_W+1:0] sw_out,
  input  logic [WORD_W-1:0] led_in,
  output logic              busy
);

  drv_state_t        state_r, state_nxt_s;
  logic [1:0]        idx_r, idx_nxt_s;
  logic [WORD_W-1:0] op_r [4];
  logic [WORD_W-1:0] word_sel_s;
  logic [WORD_W+1:0] sw_r, sw_nxt_s;
  logic [WORD_W-1:0] out_re_r, out_im_r;
  logic              in_ready_r, out_valid_r, busy_r;
  logic              load_s, done_s;

  phase_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_phase_timer (
    .clk   (clk),
    .rst_n (reset_n),
    .load  (load_s),
    .done  (done_s)
  );

  // state and word index registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= INIT_RST;
      idx_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // next-state, next index and next switch-bus value
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      INIT_RST: if (done_s) state_nxt_s = INIT_REL; else state_nxt_s = INIT_RST;
      INIT_REL: if (done_s) state_nxt_s = IDLE;     else state_nxt_s = INIT_REL;
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = WORD_HI;
          idx_nxt_s   = 2'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WORD_HI: if (done_s) state_nxt_s = WORD_LO; else state_nxt_s = WORD_HI;
      WORD_LO: begin
        if (!done_s) begin
          state_nxt_s = WORD_LO;
        end else if (idx_r == 2'd3) begin
          state_nxt_s = RES_RE;
        end else begin
          state_nxt_s = WORD_HI;
          idx_nxt_s   = idx_r + 2'd1;
        end
      end
      RES_RE:  if (done_s) state_nxt_s = RES_IM;  else state_nxt_s = RES_RE;
      RES_IM:  if (done_s) state_nxt_s = RES_END; else state_nxt_s = RES_IM;
      RES_END: if (done_s) state_nxt_s = OUT;     else state_nxt_s = RES_END;
      OUT:     if (out_ready) state_nxt_s = IDLE; else state_nxt_s = OUT;
      default: begin
        state_nxt_s = INIT_RST;
        idx_nxt_s   = 2'd0;
      end
    endcase

    // on accept the operand registers are not loaded yet, so take the port
    if (state_r == IDLE) begin
      word_sel_s = in_re_a;
    end else begin
      word_sel_s = op_r[idx_nxt_s];
    end

    sw_nxt_s             = {(WORD_W+2){1'b0}};
    sw_nxt_s[SW_RST_BIT] = (state_nxt_s != INIT_RST);
    sw_nxt_s[SW_HS_BIT]  = (state_nxt_s == WORD_HI) || (state_nxt_s == RES_IM);
    if ((state_nxt_s == WORD_HI) || (state_nxt_s == WORD_LO)) begin
      sw_nxt_s[WORD_W-1:0] = word_sel_s;
    end else begin
      sw_nxt_s[WORD_W-1:0] = {WORD_W{1'b0}};
    end
  end

  assign load_s = (state_nxt_s != state_r);

  // operand frame latched on accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) op_r[i] <= {WORD_W{1'b0}};
    end else if ((state_r == IDLE) && in_valid) begin
      op_r[0] <= in_re_a;
      op_r[1] <= in_im_a;
      op_r[2] <= in_re_q;
      op_r[3] <= in_im_q;
    end else begin
      for (int i = 0; i < 4; i++) op_r[i] <= op_r[i];
    end
  end

  // registered outputs decoded from the upcoming state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_r        <= {(WORD_W+2){1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b1;
      out_re_r    <= {WORD_W{1'b0}};
      out_im_r    <= {WORD_W{1'b0}};
    end else begin
      sw_r        <= sw_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == OUT);
      busy_r      <= (state_nxt_s != IDLE);
      if ((state_r == RES_RE) && done_s) out_re_r <= led_in;
      else                               out_re_r <= out_re_r;
      if ((state_r == RES_IM) && done_s) out_im_r <= led_in;
      else                               out_im_r <= out_im_r;
    end
  end

  assign sw_out    = sw_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_re    = out_re_r;
  assign out_im    = out_im_r;

endmodule

// File: tb/tb_cmplx_mult_driver.sv
// Scoreboard bench for cmplx_mult_driver with a behavioural multiplier
// responder on the switch/LED buses.
module tb_cmplx_mult_driver;
  import cmplx_mult_pkg::*;

  localparam int W = 8;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  word_t        in_re_a = 8'h00, in_im_a = 8'h00, in_re_q = 8'h00, in_im_q = 8'h00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  word_t        out_re, out_im;
  logic [W+1:0] sw_out;
  word_t        led_in;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_res    = 0;
  int acc_edge = 0;
  int res_edge = 0;
  logic ov_prev = 1'b0;

  word_t       exp_word_q[$];
  logic [15:0] exp_res_q[$];

  int   rcnt    = 0;
  logic hs_prev = 1'b0;
  int   hi_len  = 0;
  int   lo_len  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cmplx_mult_driver #(.WORD_W(W), .HOLD_CYCLES(H)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re_a   (in_re_a),
    .in_im_a   (in_im_a),
    .in_re_q   (in_re_q),
    .in_im_q   (in_im_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .sw_out    (sw_out),
    .led_in    (led_in),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // multiplier model: results appear on LED once all four words are in
  assign led_in = (rcnt >= 4) ? (sw_out[SW_HS_BIT] ? 8'h5A : 8'hA5) : 8'h00;

  always @(negedge clk) begin : responder
    if (!sw_out[SW_RST_BIT]) begin
      rcnt    <= 0;
      hs_prev <= 1'b0;
      hi_len  <= 0;
      lo_len  <= 0;
    end else if (sw_out[SW_HS_BIT] && !hs_prev) begin
      if (rcnt >= 1 && rcnt <= 3) chk("word_low_len", lo_len, 4);
      if (rcnt != 4) begin
        if (exp_word_q.size() == 0) begin
          chk("word_unexpected", {24'h0, sw_out[W-1:0]}, 32'hFFFF_FFFF);
        end else begin
          chk("word_data", {24'h0, sw_out[W-1:0]}, {24'h0, exp_word_q[0]});
          void'(exp_word_q.pop_front());
        end
        rcnt <= (rcnt == 5) ? 1 : rcnt + 1;
      end else begin
        rcnt <= 5;
      end
      hi_len  <= 1;
      hs_prev <= 1'b1;
    end else if (!sw_out[SW_HS_BIT] && hs_prev) begin
      chk("hs_high_len", hi_len, H);
      lo_len  <= 1;
      hs_prev <= 1'b0;
    end else if (sw_out[SW_HS_BIT]) begin
      hi_len <= hi_len + 1;
    end else begin
      lo_len <= lo_len + 1;
    end
  end

  always @(negedge clk) begin : monitor
    ov_prev <= out_valid;
    if (in_valid && in_ready) begin
      acc_edge <= cyc + 1;
      n_acc    <= n_acc + 1;
    end
    if (out_valid && !ov_prev) chk("latency", cyc - acc_edge, 11 * H);
    if (out_valid && out_ready) begin
      res_edge <= cyc + 1;
      n_res    <= n_res + 1;
      if (exp_res_q.size() == 0) begin
        chk("result_unexpected", {16'h0, out_re, out_im}, 32'hFFFF_FFFF);
      end else begin
        chk("out_re", {24'h0, out_re}, {24'h0, exp_res_q[0][15:8]});
        chk("out_im", {24'h0, out_im}, {24'h0, exp_res_q[0][7:0]});
        void'(exp_res_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_init();
    for (int k = 1; k <= 2 * H; k++) begin
      step();
      chk("init_sw", {22'h0, sw_out}, (k >= H) ? 32'h200 : 32'h000);
      chk("init_ready_busy", {30'h0, in_ready, busy}, (k >= 2 * H) ? 32'h2 : 32'h1);
    end
  endtask

  task automatic push_frame(input word_t a, input word_t b, input word_t c, input word_t d);
    exp_word_q.push_back(a);
    exp_word_q.push_back(b);
    exp_word_q.push_back(c);
    exp_word_q.push_back(d);
    exp_res_q.push_back(16'hA55A);
    in_re_a = a;
    in_im_a = b;
    in_re_q = c;
    in_im_q = d;
  endtask

  task automatic send_frame(input word_t a, input word_t b, input word_t c, input word_t d,
                            input logic keep_valid);
    for (int i = 0; i < 200 && !in_ready; i++) step();
    chk("wait_in_ready", {31'h0, in_ready}, 32'h1);
    push_frame(a, b, c, d);
    in_valid = 1'b1;
    step();
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_results(input int target);
    for (int i = 0; i < 300 && n_res < target; i++) step();
    chk("result_wait", (n_res >= target) ? 32'h1 : 32'h0, 32'h1);
  endtask

  initial begin : stimulus
    int a0, r0;
    logic [27:0] held;

    repeat (3) step();
    chk("rst_sw", {22'h0, sw_out}, 32'h0);
    chk("rst_flags", {29'h0, in_ready, out_valid, busy}, 32'h1);
    chk("rst_results", {16'h0, out_re, out_im}, 32'h0);
    reset_n = 1'b1;
    check_init();

    // single frame
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    wait_results(1);

    // backpressure
    out_ready = 1'b0;
    send_frame(8'h5C, 8'h6D, 8'h7E, 8'h8F, 1'b0);
    for (int i = 0; i < 100 && !out_valid; i++) step();
    chk("bp_valid", {31'h0, out_valid}, 32'h1);
    held = {2'b10, sw_out, out_re, out_im};
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_hold", {4'h0, out_valid, in_ready, sw_out, out_re, out_im}, {4'h0, held});
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_ready", {31'h0, in_ready}, 32'h1);
    wait_results(2);

    // back-to-back with in_valid held high
    a0 = n_acc;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
    push_frame(8'hF0, 8'hE0, 8'hD0, 8'hC0);
    wait_results(3);
    for (int i = 0; i < 10 && n_acc < a0 + 2; i++) step();
    in_valid = 1'b0;
    chk("b2b_accepts", n_acc, a0 + 2);
    chk("b2b_gap", acc_edge - res_edge, 1);
    wait_results(4);

    // reset during WORD_HI of the second word
    send_frame(8'h09, 8'h08, 8'h07, 8'h06, 1'b0);
    repeat (10) step();
    chk("mid_word1", {22'h0, sw_out}, 32'h308);
    r0 = n_res;
    reset_n = 1'b0;
    #1;
    chk("mid_reset_sw", {22'h0, sw_out}, 32'h0);
    chk("mid_reset_flags", {29'h0, in_ready, out_valid, busy}, 32'h1);
    exp_word_q.delete();
    exp_res_q.delete();
    repeat (2) step();
    reset_n = 1'b1;
    check_init();
    repeat (60) step();
    chk("aborted_no_result", n_res, r0);

    // input isolation while busy
    a0 = n_acc;
    send_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b0);
    for (int i = 0; i < 30; i++) begin
      in_valid = i[0];
      in_re_a  = word_t'($urandom_range(255, 0));
      in_im_a  = word_t'($urandom_range(255, 0));
      in_re_q  = word_t'($urandom_range(255, 0));
      in_im_q  = word_t'($urandom_range(255, 0));
      step();
    end
    in_valid = 1'b0;
    wait_results(r0 + 1);
    chk("iso_single_accept", n_acc, a0 + 1);

    repeat (5) step();
    chk("queues_drained", exp_word_q.size() + exp_res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
